pci_initiator: RTL and testbench

//  Bus-master end of our PCI-style bus: issues READ/WRITE bursts to the pci target buffer.

---
 rtl/pci_pkg.sv | 14 +
 rtl/pci_init_fifo.sv | 81 ++++++++
 rtl/pci_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_pci_initiator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared constants, FSM state type and a length check for the PCI initiator.
package pci_pkg;
  localparam logic [3:0] CMD_READ  = 4'b0110;
  localparam logic [3:0] CMD_WRITE = 4'b0111;
  localparam logic [3:0] BE_ALL    = 4'b0000;
  localparam logic [3:0] CBE_IDLE  = 4'b1111;

  typedef enum logic [1:0] {IDLE, ADDR, TURN, DATA} pci_state_t;

  // A burst length is usable when it is 1..max_burst dwords.
  function automatic logic len_legal(input logic [2:0] len, input int unsigned max_burst);
    return (len != 3'd0) && (32'(len) <= max_burst);
  endfunction
endpackage

// File: rtl/pci_init_fifo.sv
// Write staging FIFO. Besides full it exposes the head value and emptiness
// as they will be after this clock edge, so the bus-side registers can be
// loaded with the correct dword in the same cycle a beat pops the old one.
module pci_init_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_full,
  output logic [WIDTH-1:0] o_head_next,
  output logic             o_nonempty_next
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_next;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_plus1;
  logic [WIDTH-1:0] w_head;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_ok  = i_push && !o_full;
  assign w_pop_ok   = i_pop && !w_empty;
  assign w_rd_plus1 = r_rd_ptr + AW'(1);
  assign w_head     = r_mem[r_rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (i_flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_next = r_count + (AW+1)'(1);
        2'b01:   w_count_next = r_count - (AW+1)'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Head after this edge: next stored entry, or incoming data when it becomes the only one.
  always_comb begin
    o_head_next = w_head;
    if (w_pop_ok) begin
      o_head_next = (r_count >= (AW+1)'(2)) ? r_mem[w_rd_plus1] : i_push_data;
    end else if (w_empty) begin
      o_head_next = i_push_data;
    end
  end

  assign o_nonempty_next = (w_count_next != '0);

  // Pointer and count registers; flush behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/pci_initiator.sv
// PCI-style bus master: address phase, optional read turnaround, then
// 1..MAX_BURST data beats paced by the target's active-low TRDY.
// Every bus-facing output comes straight from a register.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_write,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        frame,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        IRDY,
  input  logic        TRDY
);
  localparam int WCW = $clog2(TIMEOUT + 1);

  pci_state_t r_state, w_state_next;
  logic           r_is_write, w_is_write_next;
  logic [2:0]     r_beats_left, w_beats_next;
  logic [WCW-1:0] r_wait_cnt, w_wait_next;
  logic           r_frame, w_frame_next;
  logic           r_irdy, w_irdy_next;
  logic [3:0]     r_cbe, w_cbe_next;
  logic [31:0]    r_ad_q, w_ad_q_next;
  logic           r_ad_oe, w_ad_oe_next;
  logic           r_busy, w_busy_next;
  logic           r_done, w_done_next;
  logic           r_err, w_err_next;
  logic [31:0]    r_rdata, w_rdata_next;
  logic           r_rdata_valid, w_rdata_valid_next;

  logic           w_beat, w_timeout, w_pop, w_go_idle;
  logic           w_fifo_full, w_fifo_nonempty_next;
  logic [31:0]    w_fifo_head_next;

  // A beat completes when both sides were ready at this edge.
  assign w_beat    = (r_state == DATA) && !r_irdy && !TRDY;
  // Only target stalls count toward the abort; waiting on local write data does not.
  assign w_timeout = (r_state == DATA) && !r_irdy && TRDY && (r_wait_cnt == WCW'(TIMEOUT - 1));
  assign w_pop     = w_beat && r_is_write;

  pci_init_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .i_push          (wdata_valid),
    .i_push_data     (wdata),
    .i_pop           (w_pop),
    .i_flush         (w_timeout),
    .o_full          (w_fifo_full),
    .o_head_next     (w_fifo_head_next),
    .o_nonempty_next (w_fifo_nonempty_next)
  );

  // Next-state and next-output logic for the bus FSM.
  always_comb begin
    w_state_next       = r_state;
    w_is_write_next    = r_is_write;
    w_beats_next       = r_beats_left;
    w_wait_next        = r_wait_cnt;
    w_frame_next       = r_frame;
    w_irdy_next        = r_irdy;
    w_cbe_next         = r_cbe;
    w_ad_q_next        = r_ad_q;
    w_ad_oe_next       = r_ad_oe;
    w_busy_next        = r_busy;
    w_done_next        = 1'b0;
    w_err_next         = 1'b0;
    w_rdata_next       = r_rdata;
    w_rdata_valid_next = 1'b0;
    w_go_idle          = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (len_legal(len, MAX_BURST)) begin
            w_state_next    = ADDR;
            w_is_write_next = is_write;
            w_beats_next    = len;
            w_wait_next     = '0;
            w_frame_next    = 1'b0;
            w_irdy_next     = 1'b1;
            w_cbe_next      = is_write ? CMD_WRITE : CMD_READ;
            w_ad_q_next     = addr;
            w_ad_oe_next    = 1'b1;
            w_busy_next     = 1'b1;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      ADDR: begin
        w_cbe_next = BE_ALL;
        if (r_is_write) begin
          w_state_next = DATA;
          w_frame_next = (r_beats_left == 3'd1);
          w_irdy_next  = !w_fifo_nonempty_next;
          if (w_fifo_nonempty_next) w_ad_q_next = w_fifo_head_next;
        end else begin
          w_state_next = TURN;
          w_ad_oe_next = 1'b0;
          w_irdy_next  = 1'b1;
        end
      end
      TURN: begin
        w_state_next = DATA;
        w_irdy_next  = 1'b0;
        w_frame_next = (r_beats_left == 3'd1);
      end
      DATA: begin
        if (w_beat) begin
          w_wait_next = '0;
          if (!r_is_write) begin
            w_rdata_next       = AD;
            w_rdata_valid_next = 1'b1;
          end
          if (r_beats_left == 3'd1) begin
            w_go_idle   = 1'b1;
            w_done_next = 1'b1;
          end else begin
            w_beats_next = r_beats_left - 3'd1;
            w_frame_next = (r_beats_left == 3'd2);
            if (r_is_write) begin
              w_irdy_next = !w_fifo_nonempty_next;
              if (w_fifo_nonempty_next) w_ad_q_next = w_fifo_head_next;
            end
          end
        end else if (w_timeout) begin
          w_go_idle  = 1'b1;
          w_err_next = 1'b1;
        end else if (!r_irdy) begin
          w_wait_next = r_wait_cnt + WCW'(1);
        end else if (r_is_write) begin
          w_irdy_next = !w_fifo_nonempty_next;
          if (w_fifo_nonempty_next) w_ad_q_next = w_fifo_head_next;
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_go_idle) begin
      w_state_next = IDLE;
      w_frame_next = 1'b1;
      w_irdy_next  = 1'b1;
      w_ad_oe_next = 1'b0;
      w_cbe_next   = CBE_IDLE;
      w_busy_next  = 1'b0;
      w_wait_next  = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_is_write    <= 1'b0;
      r_beats_left  <= '0;
      r_wait_cnt    <= '0;
      r_frame       <= 1'b1;
      r_irdy        <= 1'b1;
      r_cbe         <= CBE_IDLE;
      r_ad_q        <= '0;
      r_ad_oe       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_is_write    <= w_is_write_next;
      r_beats_left  <= w_beats_next;
      r_wait_cnt    <= w_wait_next;
      r_frame       <= w_frame_next;
      r_irdy        <= w_irdy_next;
      r_cbe         <= w_cbe_next;
      r_ad_q        <= w_ad_q_next;
      r_ad_oe       <= w_ad_oe_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_err         <= w_err_next;
      r_rdata       <= w_rdata_next;
      r_rdata_valid <= w_rdata_valid_next;
    end
  end

  assign AD          = r_ad_oe ? r_ad_q : 32'bz;
  assign wdata_ready = !w_fifo_full;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign frame       = r_frame;
  assign CBE         = r_cbe;
  assign IRDY        = r_irdy;
endmodule

// File: tb/tb_pci_initiator.sv
// Scoreboard bench for pci_initiator: stimulus queues expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pci_initiator;
  logic        clk = 1'b0;
  logic        rst, start, is_write, wdata_valid, TRDY;
  logic [31:0] addr, wdata;
  logic [2:0]  len;
  logic        wdata_ready, rdata_valid, busy, done, err, frame, IRDY;
  logic [31:0] rdata;
  logic [3:0]  CBE;
  wire  [31:0] AD;
  logic [31:0] tb_ad;
  logic        tb_ad_oe;

  assign AD = tb_ad_oe ? tb_ad : 32'bz;
  always #5 clk = ~clk;

  pci_initiator dut (
    .clk(clk), .rst(rst), .start(start), .is_write(is_write), .addr(addr), .len(len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done), .err(err),
    .frame(frame), .CBE(CBE), .AD(AD), .IRDY(IRDY), .TRDY(TRDY)
  );

  typedef struct packed {
    logic        is_wr;
    logic [31:0] ad;
    logic        frm;
  } beat_t;

  int          n_total = 0;
  int          n_bad   = 0;
  beat_t       q_beat[$];
  logic [31:0] q_rdata[$];
  logic [35:0] q_addr[$];
  int          q_end[$];   // 1 = done pulse, 2 = err pulse
  bit          mon_en = 1'b0;
  logic        prev_frame = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive zero onto AD briefly; any DUT drive shows up as a difference.
  task automatic check_released(input string name);
    tb_ad = 32'h0;
    tb_ad_oe = 1'b1;
    #1;
    check(name, AD, 32'h0);
    tb_ad_oe = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    wdata = d;
    wdata_valid = 1'b1;
    step();
    wdata_valid = 1'b0;
  endtask

  task automatic start_txn(input logic wr, input logic [31:0] a, input logic [2:0] l);
    is_write = wr;
    addr = a;
    len = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 60) begin
      step();
      k++;
    end
    check(name, {31'b0, busy}, 32'h0);
    step();
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d0, input int n);
    q_addr.push_back({4'b0111, a});
    for (int i = 0; i < n; i++) q_beat.push_back({1'b1, d0 + 32'(i), (i == n - 1)});
    q_end.push_back(1);
  endtask

  // Monitor: address phases, data beats, read strobes and done/err pulses.
  always @(negedge clk) begin
    beat_t       eb;
    logic [35:0] ea;
    int          ee;
    if (mon_en && !rst) begin
      if (prev_frame && !frame) begin
        if (q_addr.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL addr_phase: got unexpected addr=%h required none", AD);
        end else begin
          ea = q_addr.pop_front();
          check("addr_phase_ad", AD, ea[31:0]);
          check("addr_phase_cbe", {28'h0, CBE}, {28'h0, ea[35:32]});
        end
      end
      if (!IRDY && !TRDY) begin
        if (q_beat.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL beat: got unexpected beat ad=%h required none", AD);
        end else begin
          eb = q_beat.pop_front();
          check("beat_frame", {31'b0, frame}, {31'b0, eb.frm});
          check("beat_cbe", {28'h0, CBE}, 32'h0);
          if (eb.is_wr) check("beat_wdata", AD, eb.ad);
        end
      end
      if (rdata_valid) begin
        if (q_rdata.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL rdata: got unexpected rdata=%h required none", rdata);
        end else begin
          check("rdata", rdata, q_rdata.pop_front());
        end
      end
      if (done || err) begin
        if (q_end.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL end_pulse: got done=%0b err=%0b required none", done, err);
        end else begin
          ee = q_end.pop_front();
          check("end_done", {31'b0, done}, {31'b0, ee == 1});
          check("end_err", {31'b0, err}, {31'b0, ee == 2});
        end
      end
    end
    prev_frame = frame;
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_write = 1'b0; addr = '0; len = '0;
    wdata = '0; wdata_valid = 1'b0; TRDY = 1'b0; tb_ad = '0; tb_ad_oe = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_frame", {31'b0, frame}, 32'h1);
    check("rst_irdy", {31'b0, IRDY}, 32'h1);
    check("rst_cbe", {28'h0, CBE}, 32'hF);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_pulses", {29'b0, done, err, rdata_valid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wready", {31'b0, wdata_ready}, 32'h1);
    check_released("rst_ad_z");
    mon_en = 1'b1;

    // Write burst of 4 from a preloaded FIFO, target always ready.
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    check("fifo_full", {31'b0, wdata_ready}, 32'h0);
    exp_write(32'h10, 32'hA0, 4);
    start_txn(1'b1, 32'h10, 3'd4);
    wait_idle("wr4_idle");
    check("wr4_wready", {31'b0, wdata_ready}, 32'h1);
    check("wr4_cbe_idle", {28'h0, CBE}, 32'hF);
    check_released("wr4_ad_z");

    // Same burst with a 3-cycle target stall after beat 2.
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    exp_write(32'h10, 32'hA0, 4);
    start_txn(1'b1, 32'h10, 3'd4);
    step(); step(); step();
    TRDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_irdy", {31'b0, IRDY}, 32'h0);
      check("stall_ad", AD, 32'hA2);
      check("stall_frame", {31'b0, frame}, 32'h0);
    end
    TRDY = 1'b0;
    wait_idle("stall_idle");

    // Read burst of 2; start held an extra cycle while busy must be ignored.
    q_addr.push_back({4'b0110, 32'h20});
    q_beat.push_back({1'b0, 32'h0, 1'b0});
    q_beat.push_back({1'b0, 32'h0, 1'b1});
    q_rdata.push_back(32'hB0);
    q_rdata.push_back(32'hB1);
    q_end.push_back(1);
    is_write = 1'b0; addr = 32'h20; len = 3'd2; start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("turn_cbe", {28'h0, CBE}, 32'h0);
    check("turn_irdy", {31'b0, IRDY}, 32'h1);
    check("turn_frame", {31'b0, frame}, 32'h0);
    tb_ad = 32'hB0; tb_ad_oe = 1'b1;
    step();
    check("rd_irdy", {31'b0, IRDY}, 32'h0);
    step();
    tb_ad = 32'hB1;
    step();
    tb_ad_oe = 1'b0;
    wait_idle("rd_idle");

    // Single-dword write started with an empty FIFO; data arrives 5 cycles later.
    q_addr.push_back({4'b0111, 32'h30});
    q_beat.push_back({1'b1, 32'hC0, 1'b1});
    q_end.push_back(1);
    start_txn(1'b1, 32'h30, 3'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("empty_wait_irdy", {31'b0, IRDY}, 32'h1);
      check("empty_wait_frame", {31'b0, frame}, 32'h1);
    end
    wdata = 32'hC0; wdata_valid = 1'b1;
    step();
    wdata_valid = 1'b0;
    check("late_data_irdy", {31'b0, IRDY}, 32'h0);
    check("late_data_ad", AD, 32'hC0);
    wait_idle("late_idle");

    // Target never ready: abort after 16 stalled cycles, FIFO flushed.
    push(32'hD0);
    push(32'hD1);
    q_addr.push_back({4'b0111, 32'h40});
    q_end.push_back(2);
    TRDY = 1'b1;
    start_txn(1'b1, 32'h40, 3'd2);
    for (int i = 0; i < 16; i++) step();
    check("timeout_not_early", {31'b0, busy}, 32'h1);
    step();
    check("timeout_busy", {31'b0, busy}, 32'h0);
    check("timeout_frame", {31'b0, frame}, 32'h1);
    check("timeout_irdy", {31'b0, IRDY}, 32'h1);
    check("timeout_cbe", {28'h0, CBE}, 32'hF);
    check_released("timeout_ad_z");
    TRDY = 1'b0;
    step();
    for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i));
    check("flush_emptied", {31'b0, wdata_ready}, 32'h1);
    push(32'hE3);
    check("refill_full", {31'b0, wdata_ready}, 32'h0);

    // Illegal lengths: err pulse, no bus activity.
    q_end.push_back(2);
    start_txn(1'b1, 32'h50, 3'd0);
    check("len0_frame", {31'b0, frame}, 32'h1);
    check("len0_busy", {31'b0, busy}, 32'h0);
    step();
    q_end.push_back(2);
    start_txn(1'b0, 32'h50, 3'd5);
    check("len5_frame", {31'b0, frame}, 32'h1);
    check("len5_busy", {31'b0, busy}, 32'h0);
    step();

    // Reset during beat 2 of a write burst.
    q_addr.push_back({4'b0111, 32'h60});
    q_beat.push_back({1'b1, 32'hE0, 1'b0});
    start_txn(1'b1, 32'h60, 3'd4);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_frame", {31'b0, frame}, 32'h1);
    check("mrst_irdy", {31'b0, IRDY}, 32'h1);
    check("mrst_busy", {31'b0, busy}, 32'h0);
    check("mrst_cbe", {28'h0, CBE}, 32'hF);
    check("mrst_pulses", {30'b0, done, err}, 32'h0);
    check_released("mrst_ad_z");
    for (int i = 0; i < 3; i++) push(32'hF0 + 32'(i));
    check("mrst_fifo_empty", {31'b0, wdata_ready}, 32'h1);
    step();
    step();

    check("left_addr", 32'(q_addr.size()), 32'h0);
    check("left_beat", 32'(q_beat.size()), 32'h0);
    check("left_rdata", 32'(q_rdata.size()), 32'h0);
    check("left_end", 32'(q_end.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
